bitdet_stream_arbiter: RTL
==========================

Name: bitdet_stream_arbiter

Overview:
- Shares one bitdetector instance among N_CH independent single-bit packet streams.
- Input side: packet-level round-robin arbitration. A grant is held from the SOP beat through the EOP beat.
- Output side: the detector's result stream goes back to the channel that owns each packet. A channel-tag FIFO tracks ownership in packet order.
- Sits between the per-channel stream sources/sinks and the bitdetector's i_*/o_* stream ports.

Parameters:
- N_CH, 4, number of requester channels (2..8).
- CH_W, 2, channel index width, equal to clog2(N_CH).
- TAG_DEPTH, 4, tag FIFO depth; the maximum number of packets in flight inside the detector (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- s_valid  in  N_CH  per-channel input beat valid.
- s_sop  in  N_CH  per-channel start of packet.
- s_eop  in  N_CH  per-channel end of packet.
- s_data  in  N_CH  per-channel input bit.
- s_ready  out  N_CH  per-channel input accept.
- d_valid  out  1  to detector i_valid.
- d_sop  out  1  to detector i_sop.
- d_eop  out  1  to detector i_eop.
- d_data  out  1  to detector inp.
- d_ready  in  1  from detector i_ready.
- r_valid  in  1  from detector o_valid.
- r_sop  in  1  from detector o_sop.
- r_eop  in  1  from detector o_eop.
- r_data  in  1  from detector outp.
- r_ready  out  1  to detector o_ready.
- m_valid  out  N_CH  per-channel result valid.
- m_sop  out  N_CH  per-channel result start of packet.
- m_eop  out  N_CH  per-channel result end of packet.
- m_data  out  N_CH  per-channel result bit.
- m_ready  in  N_CH  per-channel result accept.
- grant_ch  out  CH_W  registered index of the current owner.
- busy  out  1  high while in LOCKED.

Behaviour:
- Reset values (asynchronous): state=IDLE, last_ch=N_CH-1, grant_ch=0, tag FIFO empty. All of s_ready, d_*, r_ready, m_*, busy are 0.
- Beat transfer: a beat moves on any interface only when valid && ready are both high at a rising clk edge.
- FSM IDLE:
  - Candidates are channels with s_valid && s_sop.
  - Winner is the first candidate scanning last_ch+1, last_ch+2, ... modulo N_CH.
  - If a winner exists and the FIFO is not full: grant_ch<=winner, push winner into the FIFO, go to LOCKED.
  - Arbitration latency is 1 cycle. No beat is forwarded in the IDLE cycle. d_valid=0 in IDLE.
- FSM LOCKED:
  - Combinational pass-through: d_valid/d_sop/d_eop/d_data = s_*[grant_ch], and s_ready[grant_ch]=d_ready.
  - All other s_ready bits are 0.
  - A transferred beat with s_eop=1 sets last_ch<=grant_ch and returns to IDLE next cycle.
  - A single-beat packet (sop=eop=1) occupies exactly one LOCKED cycle when d_ready=1.
- Orphan beats: in IDLE, a channel with s_valid=1 and s_sop=0 gets s_ready=1. The beat is discarded, never forwarded.
- Mid-packet SOP: a repeated s_sop in LOCKED is forwarded unchanged. No arbitration effect.
- Return path, FIFO non-empty, head channel h:
  - m_valid[h]=r_valid, m_sop[h]/m_eop[h]/m_data[h]=r_*, r_ready=m_ready[h].
  - Other channels' m_valid are 0.
- Return path, FIFO empty: r_ready=0 and all m_valid are 0.
- FIFO pop: on a transferred result beat with r_eop=1.
- Push and pop in the same cycle:
  - Both take effect.
  - The full check uses the pre-pop count. A full FIFO blocks a grant even if a pop occurs that cycle.
  - A push into an empty FIFO becomes the head next cycle.
- Reset mid-packet: everything aborts immediately to reset values. Partially sent detector packets are the detector's reset responsibility (shared reset).
- Fairness: with all channels continuously requesting, grants rotate 0,1,2,3,0,...

Optional Feature:
- Macro: BITDET_ARB_DROP_CNT_EN.
- When defined:
  - Adds output drop_cnt[15:0], which increments on each discarded orphan beat and saturates at 16'hFFFF.
  - Adds input drop_clr, which synchronously clears drop_cnt; clear wins over a simultaneous increment.
  - drop_cnt resets to 0.
- When undefined: neither port exists, and orphan beats are discarded silently.

Test Plan:
- Reset with all inputs active, then release: all outputs 0. First grant with ch0..3 requesting goes to ch0, d_valid rises 1 cycle after the IDLE cycle, grant_ch=0.
- All 4 channels send continuous 3-beat packets with d_ready=1: grant order 0,1,2,3,0. Each packet takes 1 IDLE cycle plus 3 LOCKED cycles. No beat interleaving on d_*.
- ch2 sends packet 1,0,1 while d_ready toggles 1,0,1,1: d_data sequence 1,0,1 with no duplicated or lost beat, and s_ready[2] mirrors d_ready.
- TAG_DEPTH=4 packets granted while r_valid=0: the 5th SOP request holds s_ready=0 and stays in IDLE. One r_eop transfer lets the grant issue next cycle.
- Results for packets granted as ch1 then ch3: the first result packet appears only on m_*[1] and the second only on m_*[3]. m_ready[1]=0 stalls r_ready to 0.
- Orphan beats (s_sop=0) on ch0 ×3 in IDLE: consumed with s_ready[0]=1, d_valid=0. With BITDET_ARB_DROP_CNT_EN, drop_cnt=3, then 0 after drop_clr.

Source files
------------

// File: rtl/bitdet_stream_arbiter.sv
// bitdet_stream_arbiter: shares one bitdetector between N_CH single-bit packet
// streams. Packet-level round-robin on the input side; a channel-tag FIFO routes
// the detector's result packets back to their owners in packet order.
// Optional: define BITDET_ARB_DROP_CNT_EN to add drop_cnt/drop_clr, an orphan
// beat counter.
module bitdet_stream_arbiter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned CH_W      = 2,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] s_valid,
    input  logic [N_CH-1:0] s_sop,
    input  logic [N_CH-1:0] s_eop,
    input  logic [N_CH-1:0] s_data,
    output logic [N_CH-1:0] s_ready,
    output logic            d_valid,
    output logic            d_sop,
    output logic            d_eop,
    output logic            d_data,
    input  logic            d_ready,
    input  logic            r_valid,
    input  logic            r_sop,
    input  logic            r_eop,
    input  logic            r_data,
    output logic            r_ready,
    output logic [N_CH-1:0] m_valid,
    output logic [N_CH-1:0] m_sop,
    output logic [N_CH-1:0] m_eop,
    output logic [N_CH-1:0] m_data,
    input  logic [N_CH-1:0] m_ready,
    output logic [CH_W-1:0] grant_ch,
    output logic            busy
`ifdef BITDET_ARB_DROP_CNT_EN
    ,
    input  logic            drop_clr,
    output logic [15:0]     drop_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(TAG_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CH_W-1:0]  last_ch;
    logic [CH_W-1:0]  win_ch;
    logic             win_found;
    logic             grant_fire;
    logic             eop_fire;
    logic [N_CH-1:0]  orphan_acc;
    int unsigned      scan_idx;

    logic [CH_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] tag_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [CH_W-1:0]  head_ch;

    assign fifo_full  = (tag_cnt == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (tag_cnt == '0);
    assign head_ch    = tag_mem[rd_ptr];
    assign busy       = (state_q == LOCKED);

    // Round-robin winner: first SOP requester after the last packet owner
    always_comb begin
        win_found = 1'b0;
        win_ch    = '0;
        scan_idx  = 0;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            scan_idx = (32'(last_ch) + i) % N_CH;
            if (!win_found && s_valid[CH_W'(scan_idx)] && s_sop[CH_W'(scan_idx)]) begin
                win_found = 1'b1;
                win_ch    = CH_W'(scan_idx);
            end
        end
    end

    // FSM next state and input-side routing
    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        eop_fire   = 1'b0;
        orphan_acc = '0;
        s_ready    = '0;
        d_valid    = 1'b0;
        d_sop      = 1'b0;
        d_eop      = 1'b0;
        d_data     = 1'b0;
        case (state_q)
            IDLE: begin
                // Non-SOP beats outside a packet are swallowed, never forwarded
                orphan_acc = s_valid & ~s_sop & {N_CH{~reset}};
                s_ready    = orphan_acc;
                if (win_found && !fifo_full) begin
                    grant_fire = 1'b1;
                    state_d    = LOCKED;
                end
            end
            LOCKED: begin
                d_valid           = s_valid[grant_ch];
                d_sop             = s_sop[grant_ch];
                d_eop             = s_eop[grant_ch];
                d_data            = s_data[grant_ch];
                s_ready[grant_ch] = d_ready;
                if (d_valid && d_ready && d_eop) begin
                    eop_fire = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result routing to the channel at the head of the tag FIFO
    always_comb begin
        m_valid = '0;
        m_sop   = '0;
        m_eop   = '0;
        m_data  = '0;
        r_ready = 1'b0;
        if (!fifo_empty) begin
            m_valid[head_ch] = r_valid;
            m_sop[head_ch]   = r_sop;
            m_eop[head_ch]   = r_eop;
            m_data[head_ch]  = r_data;
            r_ready          = m_ready[head_ch];
        end
        pop = r_valid && r_ready && r_eop;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Current owner and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant_ch <= '0;
            last_ch  <= CH_W'(N_CH - 1);
        end else begin
            if (grant_fire) grant_ch <= win_ch;
            if (eop_fire)   last_ch  <= grant_ch;
        end
    end

    // Tag FIFO: push on grant, pop on the result EOP; full check uses pre-pop count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_mem[i] <= '0;
        end else begin
            if (grant_fire) begin
                tag_mem[wr_ptr] <= win_ch;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({grant_fire, pop})
                2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
                2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

`ifdef BITDET_ARB_DROP_CNT_EN
    logic [3:0]  drop_inc;
    logic [16:0] drop_sum;

    // Number of orphan beats discarded this cycle
    always_comb begin
        drop_inc = '0;
        for (int unsigned i = 0; i < N_CH; i++) drop_inc = drop_inc + 4'(orphan_acc[i]);
        drop_sum = 17'(drop_cnt) + 17'(drop_inc);
    end

    // Saturating orphan counter; clear has priority over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)             drop_cnt <= '0;
        else if (drop_clr)     drop_cnt <= '0;
        else if (drop_sum[16]) drop_cnt <= 16'hFFFF;
        else                   drop_cnt <= drop_sum[15:0];
    end
`endif

endmodule
